// File: rtl/dino_pkg.sv
// Shared constants and types for the dino frame-status block: display
// geometry, sprite size, register map and STATUS bit positions.
package dino_pkg;

  localparam int HACTIVE  = 1280;
  localparam int VACTIVE  = 480;
  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 32;

  localparam logic [3:0] REG_STATUS = 4'd0;
  localparam logic [3:0] REG_FRAME  = 4'd1;
  localparam logic [3:0] REG_CTRL   = 4'd2;
  localparam logic [3:0] REG_LAST   = 4'd3;

  localparam int ST_CAC    = 0;
  localparam int ST_GOD    = 1;
  localparam int ST_VBLANK = 2;

  // Collision flags kept per frame; bit order matches STATUS[1:0] and LAST.
  typedef struct packed {
    logic god;
    logic cac;
  } hit_pair_t;

endpackage

// File: rtl/sprite_box_hit.sv
// Combinational test of whether the current pixel falls inside a 32x32
// sprite box whose origin is (x, y). Box ends are computed at 11 bits so
// origins near 255 do not wrap.
module sprite_box_hit
  import dino_pkg::*;
(
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic        hit
);

  logic [10:0] x_lo;
  logic [10:0] x_hi;
  logic [10:0] y_lo;
  logic [10:0] y_hi;
  logic [10:0] v_ext;

  // Zero-extend the origin, form the exclusive box end, and compare.
  always_comb begin
    x_lo  = {3'b000, x};
    y_lo  = {3'b000, y};
    x_hi  = x_lo + 11'(SPRITE_W);
    y_hi  = y_lo + 11'(SPRITE_H);
    v_ext = {1'b0, vcount};
    hit   = (hcount >= x_lo) && (hcount < x_hi) &&
            (v_ext >= y_lo) && (v_ext < y_hi);
  end

endmodule

// File: rtl/dino_frame_status.sv
// Per-frame collision status for the dino game: accumulates dino/cactus and
// dino/bird overlaps over the active picture, latches them at frame end and
// exposes STATUS, FRAME_COUNT, CTRL and LAST on a small CPU register bus.
// Optional feature macro: DINO_STATUS_IRQ_EN (CTRL.irq_en and the irq line).
module dino_frame_status
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [7:0]  dino_x,
  input  logic [7:0]  dino_y,
  input  logic [7:0]  cac_x,
  input  logic [7:0]  cac_y,
  input  logic [7:0]  god_x,
  input  logic [7:0]  god_y
);

  logic        dino_hit;
  logic        cac_hit;
  logic        god_hit;
  logic        active_pixel;
  logic        frame_end;
  logic        rd_acc;
  logic        irq_en_rd;

  hit_pair_t   acc_q, acc_d;
  hit_pair_t   last_q, last_d;
  logic [2:0]  status_q, status_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [31:0] readdata_q, readdata_d;

  sprite_box_hit u_dino_hit (.hcount(hcount), .vcount(vcount), .x(dino_x), .y(dino_y), .hit(dino_hit));
  sprite_box_hit u_cac_hit  (.hcount(hcount), .vcount(vcount), .x(cac_x),  .y(cac_y),  .hit(cac_hit));
  sprite_box_hit u_god_hit  (.hcount(hcount), .vcount(vcount), .x(god_x),  .y(god_y),  .hit(god_hit));

  // Accumulate collisions, then at frame end hand them to LAST/STATUS; a frame-end set overrides a same-cycle STATUS clear.
  always_comb begin
    active_pixel  = (hcount < 11'(HACTIVE)) && (vcount < 10'(VACTIVE));
    frame_end     = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
    rd_acc        = chipselect & read;
    acc_d         = acc_q;
    last_d        = last_q;
    status_d      = status_q;
    frame_count_d = frame_count_q;
    if (active_pixel) begin
      if (dino_hit && cac_hit) acc_d.cac = 1'b1;
      if (dino_hit && god_hit) acc_d.god = 1'b1;
    end
    if (rd_acc && (address == REG_STATUS)) begin
      status_d = 3'b000;
    end
    if (frame_end) begin
      last_d              = acc_q;
      status_d[ST_CAC]    = status_d[ST_CAC] | acc_q.cac;
      status_d[ST_GOD]    = status_d[ST_GOD] | acc_q.god;
      status_d[ST_VBLANK] = 1'b1;
      acc_d               = '0;
      frame_count_d       = frame_count_q + 16'd1;
    end
  end

  // Read mux samples the pre-update register values and holds between reads.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_acc) begin
      case (address)
        REG_STATUS: readdata_d = {29'd0, status_q};
        REG_FRAME:  readdata_d = {16'd0, frame_count_q};
        REG_CTRL:   readdata_d = {31'd0, irq_en_rd};
        REG_LAST:   readdata_d = {30'd0, last_q};
        default:    readdata_d = 32'd0;
      endcase
    end
  end

  // Core state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q         <= '0;
      last_q        <= '0;
      status_q      <= 3'b000;
      frame_count_q <= 16'd0;
      readdata_q    <= 32'd0;
    end else begin
      acc_q         <= acc_d;
      last_q        <= last_d;
      status_q      <= status_d;
      frame_count_q <= frame_count_d;
      readdata_q    <= readdata_d;
    end
  end

  assign readdata = readdata_q;

`ifdef DINO_STATUS_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;
  logic unused_wdata;

  // CTRL write path and the registered level interrupt.
  always_comb begin
    irq_en_d = irq_en_q;
    if (chipselect && write && (address == REG_CTRL)) begin
      irq_en_d = writedata[0];
    end
    irq_d = irq_en_d & status_d[ST_VBLANK];
  end

  // Interrupt enable and interrupt output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq          = irq_q;
  assign irq_en_rd    = irq_en_q;
  assign unused_wdata = ^writedata[31:1];
`else
  logic unused_wdata;

  assign irq          = 1'b0;
  assign irq_en_rd    = 1'b0;
  assign unused_wdata = ^{write, writedata};
`endif

endmodule

// File: tb/tb_dino_frame_status.sv
// Self-checking bench for dino_frame_status: table-driven register accesses
// with a readdata scoreboard plus hand-written frame/reset/irq sequences.
// Frames are compressed: a sparse raster sweep followed by one frame-end cycle.
module tb_dino_frame_status;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, read, write;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [7:0]  dino_x, dino_y, cac_x, cac_y, god_x, god_y;

`ifdef DINO_STATUS_IRQ_EN
  localparam logic [31:0] IRQ_BUILD = 32'd1;
`else
  localparam logic [31:0] IRQ_BUILD = 32'd0;
`endif

  typedef struct {
    bit          do_rd;
    bit          do_wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t  sb_q[$];
  vec_t tbl_reset[$];
  vec_t tbl_regs[$];
  int   total = 0;
  int   bad   = 0;

  always #10 clk = ~clk;

  dino_frame_status dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata), .irq(irq),
    .hcount(hcount), .vcount(vcount),
    .dino_x(dino_x), .dino_y(dino_y), .cac_x(cac_x), .cac_y(cac_y),
    .god_x(god_x), .god_y(god_y)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rd, input bit wr, input logic [3:0] a,
                              input logic [31:0] wd, input logic [31:0] e, input string n);
    vec_t v;
    v.do_rd = rd; v.do_wr = wr; v.addr = a; v.wdata = wd; v.exp = e; v.name = n;
    return v;
  endfunction

  // One bus cycle; a read pushes its expected readdata to the scoreboard.
  task automatic applyStimulus(input vec_t v);
    sb_t s;
    chipselect = v.do_rd | v.do_wr;
    read       = v.do_rd;
    write      = v.do_wr;
    address    = v.addr;
    writedata  = v.wdata;
    if (v.do_rd) begin
      s.exp  = v.exp;
      s.name = v.name;
      sb_q.push_back(s);
    end
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] e, input string n);
    applyStimulus(mk(1'b1, 1'b0, a, 32'd0, e, n));
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    applyStimulus(mk(1'b0, 1'b1, a, d, 32'd0, "wr"));
  endtask

  task automatic park();
    hcount = 11'd1280;
    vcount = 10'd480;
  endtask

  task automatic sweep_rows(input int v_lo, input int v_hi);
    for (int v = v_lo; v < v_hi; v += 16) begin
      for (int h = 0; h < 256; h += 8) begin
        hcount = 11'(h);
        vcount = 10'(v);
        @(negedge clk);
      end
    end
    park();
  endtask

  task automatic frame_end_pulse();
    hcount = 11'd0;
    vcount = 10'd480;
    @(negedge clk);
    park();
  endtask

  task automatic run_frame();
    sweep_rows(0, 480);
    frame_end_pulse();
  endtask

  task automatic set_sprites(input int dx, input int dy, input int cx, input int cy,
                             input int gx, input int gy);
    dino_x = 8'(dx); dino_y = 8'(dy);
    cac_x  = 8'(cx); cac_y  = 8'(cy);
    god_x  = 8'(gx); god_y  = 8'(gy);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  // Scoreboard consumer: every accepted read is checked one cycle later.
  always @(posedge clk) begin
    if (reset && chipselect && read) begin
      #1;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_underflow: got readdata 0x%0h, expected a queued entry", readdata);
      end else begin
        sb_t s;
        s = sb_q.pop_front();
        checkOutput(s.name, readdata, s.exp);
      end
    end
  end

  initial begin
    tbl_reset.push_back(mk(1, 0, 4'd0, 0, 32'h0, "rst_status"));
    tbl_reset.push_back(mk(1, 0, 4'd1, 0, 32'h0, "rst_frame"));
    tbl_reset.push_back(mk(1, 0, 4'd2, 0, 32'h0, "rst_ctrl"));
    tbl_reset.push_back(mk(1, 0, 4'd3, 0, 32'h0, "rst_last"));

    tbl_regs.push_back(mk(1, 0, 4'd0, 0, 32'h5, "status_cac_vblank"));
    tbl_regs.push_back(mk(1, 0, 4'd3, 0, 32'h1, "last_cac"));
    tbl_regs.push_back(mk(1, 0, 4'd0, 0, 32'h0, "status_cleared"));
    tbl_regs.push_back(mk(1, 0, 4'd1, 0, 32'h1, "frame_count_1"));
    tbl_regs.push_back(mk(0, 1, 4'd0, 32'hFFFF_FFFF, 0, "wr_status"));
    tbl_regs.push_back(mk(0, 1, 4'd1, 32'hFFFF_FFFF, 0, "wr_frame"));
    tbl_regs.push_back(mk(0, 1, 4'd3, 32'hFFFF_FFFF, 0, "wr_last"));
    tbl_regs.push_back(mk(1, 0, 4'd0, 0, 32'h0, "status_wr_ignored"));
    tbl_regs.push_back(mk(1, 0, 4'd1, 0, 32'h1, "frame_wr_ignored"));
    tbl_regs.push_back(mk(1, 0, 4'd3, 0, 32'h1, "last_wr_ignored"));
    tbl_regs.push_back(mk(1, 1, 4'd2, 32'h1, 32'h0, "ctrl_rdwr_old"));
    tbl_regs.push_back(mk(1, 0, 4'd2, 0, IRQ_BUILD, "ctrl_after_write"));
    tbl_regs.push_back(mk(0, 1, 4'd2, 32'h0, 0, "wr_ctrl_0"));
    tbl_regs.push_back(mk(1, 0, 4'd2, 0, 32'h0, "ctrl_cleared"));
    tbl_regs.push_back(mk(1, 0, 4'd9, 0, 32'h0, "unmapped_9"));
    tbl_regs.push_back(mk(1, 0, 4'd15, 0, 32'h0, "unmapped_15"));

    reset = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = 4'd0; writedata = 32'd0;
    park();
    set_sprites(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("rst_readdata", readdata, 32'h0);
    checkOutput("rst_irq", {31'd0, irq}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    foreach (tbl_reset[i]) applyStimulus(tbl_reset[i]);

    $display("[TB] one frame with dino/cactus overlap, then register table");
    set_sprites(100, 100, 120, 110, 200, 300);
    run_frame();
    foreach (tbl_regs[i]) applyStimulus(tbl_regs[i]);

    $display("[TB] STATUS read coinciding with frame end");
    run_frame();
    sweep_rows(0, 480);
    begin
      sb_t s;
      hcount = 11'd0; vcount = 10'd480;
      chipselect = 1'b1; read = 1'b1; address = 4'd0;
      s.exp = 32'h5; s.name = "status_read_on_frame_end";
      sb_q.push_back(s);
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0;
      park();
    end
    bus_read(4'd0, 32'h5, "status_set_wins");
    bus_read(4'd3, 32'h1, "last_after_set_wins");
    bus_read(4'd0, 32'h0, "status_cleared_again");
    bus_read(4'd1, 32'h3, "frame_count_3");

    $display("[TB] interrupt sequence");
    bus_write(4'd2, 32'h1);
    sweep_rows(0, 480);
    checkOutput("irq_before_event", {31'd0, irq}, 32'h0);
    hcount = 11'd0; vcount = 10'd480;
    @(negedge clk);
    park();
    checkOutput("irq_rises", {31'd0, irq}, IRQ_BUILD);
    bus_read(4'd0, 32'h5, "status_irq_frame");
    checkOutput("irq_after_clear", {31'd0, irq}, 32'h0);
    bus_read(4'd2, IRQ_BUILD, "ctrl_irq_en");
    bus_write(4'd2, 32'h0);

    $display("[TB] disjoint sprites, three frames after reset");
    do_reset(3);
    bus_read(4'd1, 32'h0, "frame_after_reset");
    bus_read(4'd3, 32'h0, "last_after_reset");
    bus_read(4'd0, 32'h0, "status_after_reset");
    set_sprites(10, 10, 200, 200, 100, 300);
    repeat (3) run_frame();
    bus_read(4'd0, 32'h4, "status_disjoint");
    bus_read(4'd1, 32'h3, "frame_count_disjoint");
    bus_read(4'd3, 32'h0, "last_disjoint");
    checkOutput("irq_disabled", {31'd0, irq}, 32'h0);

    $display("[TB] reset mid-frame discards partial accumulation");
    set_sprites(100, 100, 200, 10, 110, 110);
    sweep_rows(0, 240);
    hcount = 11'd0; vcount = 10'd240;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    god_x = 8'd10; god_y = 8'd300 - 8'd0;
    god_y = 8'd44;
    reset = 1'b1;
    sweep_rows(240, 480);
    frame_end_pulse();
    bus_read(4'd0, 32'h4, "status_post_reset_frame");
    bus_read(4'd3, 32'h0, "last_post_reset_frame");
    bus_read(4'd1, 32'h1, "frame_post_reset_frame");

    $display("[TB] frame counter wrap");
    do_reset(2);
    hcount = 11'd0; vcount = 10'd480;
    repeat (65535) @(negedge clk);
    park();
    bus_read(4'd1, 32'h0000_FFFF, "frame_count_ffff");
    bus_read(4'd0, 32'h4, "status_before_wrap");
    frame_end_pulse();
    bus_read(4'd1, 32'h0, "frame_count_wrap");
    bus_read(4'd0, 32'h4, "status_after_wrap");

    @(negedge clk);
    checkOutput("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
